// File: rtl/axi_llc_pkg.sv
// Shared LLC types: tag-SRAM scheduler state and the tag SRAM request record.
// The request record here is sized for the default tag geometry.
package axi_llc_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } tag_sched_state_e;

    localparam int unsigned TagAddrWidth = 10;
    localparam int unsigned TagDataWidth = 128;
    localparam int unsigned TagBeWidth   = 16;

    // Arbiter request/grant bit positions.
    localparam int unsigned ReqLookup = 0;
    localparam int unsigned ReqUpdate = 1;

    typedef struct packed {
        logic                    we;
        logic [TagAddrWidth-1:0] addr;
        logic [TagDataWidth-1:0] wdata;
        logic [TagBeWidth-1:0]   be;
    } tag_sram_req_t;

endpackage

// File: rtl/axi_llc_tag_rr_arb.sv
// Two-requester round-robin arbiter; rr_q names the side that wins a tie.
module axi_llc_tag_rr_arb
    import axi_llc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] elig_i,
    output logic [1:0] gnt_o
);

    logic rr_q, rr_d;

    // rr_q == 0 favours lookup; only a contested grant moves the pointer.
    always_comb begin
        gnt_o = elig_i;
        rr_d  = rr_q;
        if (elig_i == 2'b11) begin
            gnt_o = '0;
            if (rr_q) begin
                gnt_o[ReqUpdate] = 1'b1;
            end else begin
                gnt_o[ReqLookup] = 1'b1;
            end
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/axi_llc_tag_sram_sched.sv
// Shares one single-port tag SRAM between lookup reads and update writes,
// and clears the whole array after reset and on flush.
module axi_llc_tag_sram_sched
    import axi_llc_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    output logic                 init_done_o,
    input  logic                 lookup_valid_i,
    output logic                 lookup_ready_o,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    input  logic                 update_valid_i,
    output logic                 update_ready_o,
    input  logic [AddrWidth-1:0] update_addr_i,
    input  logic [DataWidth-1:0] update_data_i,
    input  logic [BeWidth-1:0]   update_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0] sram_wdata_o,
    output logic [BeWidth-1:0]   sram_be_o,
    input  logic [DataWidth-1:0] sram_rdata_i
);

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [BeWidth-1:0]   be_t;

    typedef struct packed {
        logic  we;
        addr_t addr;
        data_t wdata;
        be_t   be;
    } sram_req_t;

    localparam addr_t LastAddr = addr_t'(NumWords - 1);

    // Handshakes: valid never depends on ready; a transfer happens in any
    // cycle where valid && ready. Ready here is the arbiter grant itself.
    tag_sched_state_e state_q, state_d;
    addr_t            cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_fresh_q;
    data_t            hold_q;
    logic [1:0]       elig, gnt;
    logic             sweep_req;
    sram_req_t        req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_o = 1'b0;
        elig        = '0;
        sweep_req   = 1'b0;
        if (!rst_i) begin
            case (state_q)
                SWEEP: begin
                    sweep_req = 1'b1;
                    if (cnt_q == LastAddr) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + addr_t'(1);
                    end
                end
                RUN: begin
                    init_done_o = 1'b1;
                    if (flush_i) begin
                        state_d = SWEEP;
                    end else begin
                        elig[ReqLookup] = lookup_valid_i && (!rsp_valid_q || rsp_ready_i);
                        elig[ReqUpdate] = update_valid_i;
                    end
                end
                default: state_d = SWEEP;
            endcase
        end
    end

    axi_llc_tag_rr_arb u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .elig_i (elig),
        .gnt_o  (gnt)
    );

    assign lookup_ready_o = gnt[ReqLookup];
    assign update_ready_o = gnt[ReqUpdate];

    always_comb begin
        req        = '0;
        sram_req_o = 1'b0;
        if (sweep_req) begin
            sram_req_o = 1'b1;
            req.we     = 1'b1;
            req.addr   = cnt_q;
            req.be     = '1;
        end else if (gnt[ReqLookup]) begin
            sram_req_o = 1'b1;
            req.addr   = lookup_addr_i;
        end else if (gnt[ReqUpdate]) begin
            sram_req_o = 1'b1;
            req.we     = 1'b1;
            req.addr   = update_addr_i;
            req.wdata  = update_data_i;
            req.be     = update_be_i;
        end
    end

    assign sram_we_o    = req.we;
    assign sram_addr_o  = req.addr;
    assign sram_wdata_o = req.wdata;
    assign sram_be_o    = req.be;

    // Read data is live only in the cycle right after the read; a stalled
    // response replays the captured copy so later writes cannot disturb it.
    assign rsp_valid_d = gnt[ReqLookup] || (rsp_valid_q && !rsp_ready_i);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_fresh_q ? sram_rdata_i : hold_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SWEEP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fresh_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fresh_q <= gnt[ReqLookup];
            if (rsp_fresh_q) begin
                hold_q <= sram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_axi_llc_tag_sram_sched.sv
// Bench for axi_llc_tag_sram_sched with a 16-word, 64-bit behavioural SRAM
// and a shadow-memory/response-queue reference model.
module tb_axi_llc_tag_sram_sched;

    localparam int NW = 16;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst, flush, lv, uv, rsp_ready;
    logic [AW-1:0] la, ua;
    logic [DW-1:0] ud;
    logic [BW-1:0] ube;

    logic          init_done_o, lookup_ready_o, update_ready_o, rsp_valid_o;
    logic [DW-1:0] rsp_data_o;
    logic          sram_req_o, sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [BW-1:0] sram_be_o;
    logic [DW-1:0] sram_rdata = '0;

    axi_llc_tag_sram_sched #(.NumWords(NW), .DataWidth(DW), .ByteWidth(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .init_done_o    (init_done_o),
        .lookup_valid_i (lv),
        .lookup_ready_o (lookup_ready_o),
        .lookup_addr_i  (la),
        .update_valid_i (uv),
        .update_ready_o (update_ready_o),
        .update_addr_i  (ua),
        .update_data_i  (ud),
        .update_be_i    (ube),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data_o),
        .sram_req_o     (sram_req_o),
        .sram_we_o      (sram_we_o),
        .sram_addr_o    (sram_addr_o),
        .sram_wdata_o   (sram_wdata_o),
        .sram_be_o      (sram_be_o),
        .sram_rdata_i   (sram_rdata)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM macro model, read latency 1 ----------------
    logic [DW-1:0] mem [NW];
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr_o];
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] exp_q [$];
    logic          m_sweep, m_lookup_first;
    int            m_cnt;
    int            n_vec = 0;
    int            n_err = 0;
    logic          obs_init, obs_l, obs_u;
    logic [DW-1:0] obs_rsp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    endtask

    // One clock: check outputs for the inputs now applied, advance the model.
    task automatic cycle();
        logic el, eu, gl, gu;
        #1;
        obs_init = init_done_o;
        obs_l    = lookup_ready_o;
        obs_u    = update_ready_o;
        obs_rsp  = rsp_data_o;
        gl = 1'b0;
        gu = 1'b0;
        if (rst) begin
            check("rst_init", init_done_o, 0);
            check("rst_lrdy", lookup_ready_o, 0);
            check("rst_urdy", update_ready_o, 0);
            check("rst_req", sram_req_o, 0);
        end else if (m_sweep) begin
            check("swp_init", init_done_o, 0);
            check("swp_lrdy", lookup_ready_o, 0);
            check("swp_urdy", update_ready_o, 0);
            check("swp_req", sram_req_o, 1);
            check("swp_we", sram_we_o, 1);
            check("swp_addr", sram_addr_o, m_cnt);
            check("swp_wdata", sram_wdata_o, 0);
            check("swp_be", sram_be_o, 8'hFF);
        end else begin
            check("run_init", init_done_o, 1);
            if (!flush) begin
                el = lv && (exp_q.size() == 0 || rsp_ready);
                eu = uv;
                if (el && eu) begin
                    if (m_lookup_first) gl = 1'b1; else gu = 1'b1;
                    m_lookup_first = !m_lookup_first;
                end else begin
                    gl = el;
                    gu = eu;
                end
            end
            check("lrdy", lookup_ready_o, gl);
            check("urdy", update_ready_o, gu);
            check("req", sram_req_o, gl | gu);
            if (gl) begin
                check("lk_we", sram_we_o, 0);
                check("lk_addr", sram_addr_o, la);
            end
            if (gu) begin
                check("up_we", sram_we_o, 1);
                check("up_addr", sram_addr_o, ua);
                check("up_wdata", sram_wdata_o, ud);
                check("up_be", sram_be_o, ube);
            end
        end
        if (!rst) begin
            check("rsp_valid", rsp_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0) check("rsp_data", rsp_data_o, exp_q[0]);
        end
        if (rst) begin
            m_sweep = 1'b1;
            m_cnt = 0;
            m_lookup_first = 1'b1;
            exp_q.delete();
            clear_ref();
        end else begin
            if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
            if (gl) exp_q.push_back(ref_mem[la]);
            if (gu)
                for (int b = 0; b < BW; b++)
                    if (ube[b]) ref_mem[ua][b*8 +: 8] = ud[b*8 +: 8];
            if (m_sweep) begin
                m_cnt++;
                if (m_cnt == NW) begin
                    m_sweep = 1'b0;
                    m_cnt = 0;
                end
            end else if (flush) begin
                m_sweep = 1'b1;
                m_cnt = 0;
                clear_ref();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        lv = 1'b0; uv = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    endtask

    // Counts cycles with init_done_o low until it rises, bounded.
    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        obs_init = 1'b0;
        while (!obs_init && n < 100) begin
            cycle();
            if (!obs_init) n++;
        end
        check(tag, n, NW);
    endtask

    task automatic do_update(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        idle(); uv = 1'b1; ua = a; ud = d; ube = be;
        cycle();
        idle();
    endtask

    task automatic do_lookup_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        idle(); lv = 1'b1; la = a;
        cycle();
        idle();
        cycle();
        check(tag, obs_rsp, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nl, nu;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        clear_ref();
        m_sweep = 1'b1; m_cnt = 0; m_lookup_first = 1'b1;
        rst = 1'b1; flush = 1'b0; lv = 1'b0; uv = 1'b0; rsp_ready = 1'b1;
        la = '0; ua = '0; ud = '0; ube = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        wait_sweep("init_sweep_len");

        // Contention right after reset: strict L,U alternation.
        nl = 0; nu = 0;
        lv = 1'b1; uv = 1'b1; rsp_ready = 1'b1; la = 4'd1; ua = 4'd2; ube = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            ud = {$urandom, $urandom};
            cycle();
            check("alt_order", obs_l, (i % 2) == 0);
            nl += obs_l;
            nu += obs_u;
        end
        check("alt_lookups", nl, 4);
        check("alt_updates", nu, 4);
        idle();
        cycle();

        do_update(4'd5, {8{8'hA5}}, 8'hFF);
        do_lookup_check("full_write", 4'd5, {8{8'hA5}});

        do_update(4'd3, {8{8'hFF}}, 8'h01);
        do_lookup_check("byte_lane", 4'd3, 64'h0000_0000_0000_00FF);

        // Stalled response while the same word is overwritten.
        idle(); lv = 1'b1; la = 4'd5;
        cycle();
        rsp_ready = 1'b0; lv = 1'b1; la = 4'd6; uv = 1'b1; ua = 4'd5; ube = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            ud = {$urandom, $urandom};
            cycle();
            check("stall_data", obs_rsp, {8{8'hA5}});
            check("stall_lrdy", obs_l, 0);
            check("stall_urdy", obs_u, 1);
        end
        idle();
        cycle();
        cycle();

        // Flush clears previously written data.
        do_update(4'd7, 64'h1, 8'hFF);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wait_sweep("flush_sweep_len");
        do_lookup_check("after_flush", 4'd7, 64'h0);

        // Reset in the middle of a sweep restarts it from word 0.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wait_sweep("midsweep_rst_len");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            lv        = $urandom_range(0, 1);
            uv        = $urandom_range(0, 1);
            la        = AW'($urandom_range(0, NW - 1));
            ua        = AW'($urandom_range(0, NW - 1));
            ud        = {$urandom, $urandom};
            ube       = BW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
